// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the AXI4 manager arbiter: FSM state encodings
// for the independent write and read paths plus sizing constants.
package axi4_arb_pkg;

  localparam int ARB_MAX_MGR = 4;
  localparam int BEATCNT_W   = 9;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after ptr wins.
// Returns a one-hot grant and its encoded index; all zero when disabled.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin : arb
    logic found;
    int   idx;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Scan candidates in rotating order starting just after the last winner.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      for (int i = 0; i < N; i++) begin
        if (i == idx && en && !found && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = IW'(i);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi4_mgr_arbiter.sv
// Shares one AXI4 subordinate port between NUM_MGR managers. Write and read
// paths are arbitrated independently and hold their grant for a full transaction.
module axi4_mgr_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_MGR   = 2,
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = ADDRWIDTH
) (
  input  logic                           clk,
  input  logic                           nreset,
  // Manager-side ports, manager i occupies slice i of every vector
  input  logic [NUM_MGR*ADDRWIDTH-1:0]   m_awaddr,
  input  logic [NUM_MGR-1:0]             m_awvalid,
  output logic [NUM_MGR-1:0]             m_awready,
  input  logic [NUM_MGR*3-1:0]           m_awprot,
  input  logic [NUM_MGR*8-1:0]           m_awlen,
  input  logic [NUM_MGR*DATAWIDTH-1:0]   m_wdata,
  input  logic [NUM_MGR*DATAWIDTH/8-1:0] m_wstrb,
  input  logic [NUM_MGR-1:0]             m_wlast,
  input  logic [NUM_MGR-1:0]             m_wvalid,
  output logic [NUM_MGR-1:0]             m_wready,
  output logic [NUM_MGR-1:0]             m_bvalid,
  input  logic [NUM_MGR-1:0]             m_bready,
  input  logic [NUM_MGR*ADDRWIDTH-1:0]   m_araddr,
  input  logic [NUM_MGR*3-1:0]           m_arprot,
  input  logic [NUM_MGR*8-1:0]           m_arlen,
  input  logic [NUM_MGR-1:0]             m_arvalid,
  output logic [NUM_MGR-1:0]             m_arready,
  output logic [NUM_MGR*DATAWIDTH-1:0]   m_rdata,
  output logic [NUM_MGR-1:0]             m_rvalid,
  input  logic [NUM_MGR-1:0]             m_rready,
  // Subordinate-side port
  output logic [ADDRWIDTH-1:0]           s_awaddr,
  output logic [2:0]                     s_awprot,
  output logic [7:0]                     s_awlen,
  output logic                           s_awvalid,
  input  logic                           s_awready,
  output logic [DATAWIDTH-1:0]           s_wdata,
  output logic [DATAWIDTH/8-1:0]         s_wstrb,
  output logic                           s_wlast,
  output logic                           s_wvalid,
  input  logic                           s_wready,
  input  logic                           s_bvalid,
  output logic                           s_bready,
  output logic [ADDRWIDTH-1:0]           s_araddr,
  output logic [2:0]                     s_arprot,
  output logic [7:0]                     s_arlen,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  input  logic [DATAWIDTH-1:0]           s_rdata,
  input  logic                           s_rvalid,
  output logic                           s_rready
);

  localparam int IW = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;
  localparam int SW = DATAWIDTH / 8;

  wr_state_e              w_state, w_state_nxt;
  rd_state_e              r_state, r_state_nxt;
  // The registered grant index doubles as the round-robin pointer.
  logic [IW-1:0]          w_gnt, r_gnt;
  logic [NUM_MGR-1:0]     w_arb_gnt, r_arb_gnt;
  logic [IW-1:0]          w_arb_idx, r_arb_idx;
  logic                   aw_done, w_done;
  logic                   aw_hs, wl_hs, b_hs, ar_hs, r_hs;
  logic [BEATCNT_W-1:0]   r_cnt;

  rr_arbiter #(.N(NUM_MGR)) u_w_arb (
    .req     (m_awvalid),
    .en      (w_state == W_IDLE),
    .ptr     (w_gnt),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx)
  );

  rr_arbiter #(.N(NUM_MGR)) u_r_arb (
    .req     (m_arvalid),
    .en      (r_state == R_IDLE),
    .ptr     (r_gnt),
    .gnt     (r_arb_gnt),
    .gnt_idx (r_arb_idx)
  );

  assign aw_hs = s_awvalid & s_awready;
  assign wl_hs = s_wvalid & s_wready & s_wlast;
  assign b_hs  = s_bvalid & s_bready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  // Write path
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      w_state <= W_IDLE;
      w_gnt   <= IW'(NUM_MGR - 1);
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      w_state <= w_state_nxt;
      if (w_state == W_IDLE && |w_arb_gnt) begin
        w_gnt   <= w_arb_idx;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (w_state == W_XFER) begin
        if (aw_hs) aw_done <= 1'b1;
        if (wl_hs) w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (|w_arb_gnt) w_state_nxt = W_XFER;
      W_XFER:  if ((aw_done | aw_hs) && (w_done | wl_hs)) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_awaddr  = '0;
    s_awprot  = '0;
    s_awlen   = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (IW'(i) == w_gnt) begin
        if (w_state == W_XFER) begin
          s_awaddr     = m_awaddr[i*ADDRWIDTH +: ADDRWIDTH];
          s_awprot     = m_awprot[i*3 +: 3];
          s_awlen      = m_awlen[i*8 +: 8];
          s_awvalid    = m_awvalid[i] & ~aw_done;
          m_awready[i] = s_awready & ~aw_done;
          s_wdata      = m_wdata[i*DATAWIDTH +: DATAWIDTH];
          s_wstrb      = m_wstrb[i*SW +: SW];
          s_wlast      = m_wlast[i];
          s_wvalid     = m_wvalid[i] & ~w_done;
          m_wready[i]  = s_wready & ~w_done;
        end
        if (w_state == W_RESP) begin
          m_bvalid[i] = s_bvalid;
          s_bready    = m_bready[i];
        end
      end
    end
  end

  // Read path; the subordinate has no rlast, so completion comes from r_cnt.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= R_IDLE;
      r_gnt   <= IW'(NUM_MGR - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (r_state == R_IDLE && |r_arb_gnt) begin
        r_gnt <= r_arb_idx;
      end else if (r_state == R_ADDR && ar_hs) begin
        r_cnt <= {1'b0, s_arlen} + BEATCNT_W'(1);
      end else if (r_state == R_DATA && r_hs) begin
        r_cnt <= r_cnt - BEATCNT_W'(1);
      end
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (|r_arb_gnt) r_state_nxt = R_ADDR;
      R_ADDR:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_cnt == BEATCNT_W'(1)) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_araddr  = '0;
    s_arprot  = '0;
    s_arlen   = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (IW'(i) == r_gnt) begin
        if (r_state == R_ADDR) begin
          s_araddr     = m_araddr[i*ADDRWIDTH +: ADDRWIDTH];
          s_arprot     = m_arprot[i*3 +: 3];
          s_arlen      = m_arlen[i*8 +: 8];
          s_arvalid    = m_arvalid[i];
          m_arready[i] = s_arready;
        end
        if (r_state == R_DATA) begin
          m_rvalid[i]                        = s_rvalid;
          m_rdata[i*DATAWIDTH +: DATAWIDTH]  = s_rdata;
          s_rready                           = m_rready[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_mgr_arbiter.sv
// Directed self-checking bench for axi4_mgr_arbiter with two 32-bit managers;
// the subordinate side is driven directly by each scenario task.
module tb_axi4_mgr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              nreset;
  logic [N*AW-1:0]   m_awaddr, m_araddr;
  logic [N-1:0]      m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [N-1:0]      m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*3-1:0]    m_awprot, m_arprot;
  logic [N*8-1:0]    m_awlen, m_arlen;
  logic [N*DW-1:0]   m_wdata, m_rdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [AW-1:0]     s_awaddr, s_araddr;
  logic [2:0]        s_awprot, s_arprot;
  logic [7:0]        s_awlen, s_arlen;
  logic              s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [DW/8-1:0]   s_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  axi4_mgr_arbiter #(.NUM_MGR(N), .ADDRWIDTH(AW), .DATAWIDTH(DW)) u_dut (
    .clk(clk), .nreset(nreset),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awprot(m_awprot), .m_awlen(m_awlen),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_awaddr = '0; m_awvalid = '0; m_awprot = '0; m_awlen = '0;
    m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    m_araddr = '0; m_arprot = '0; m_arlen = '0; m_arvalid = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    clear_inputs();
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    clear_inputs();
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = '1;
    m_awvalid = '1; m_wvalid = '1; m_arvalid = '1; m_bready = '1; m_rready = '1;
    m_awaddr = '1; m_araddr = '1; m_wdata = '1;
    settle();
    n_cmp++;
    if ({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_s_ctrl: got %b exp 00000", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready});
    end
    n_cmp++;
    if ({m_awready, m_wready, m_bvalid, m_arready, m_rvalid} !== 10'b0) begin
      n_err++;
      $display("FAIL rst_m_ctrl: got %b exp 0", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid});
    end
    n_cmp++;
    if ({s_awaddr, s_araddr, s_wdata} !== '0) begin
      n_err++;
      $display("FAIL rst_s_data: got %h %h %h exp 0", s_awaddr, s_araddr, s_wdata);
    end
    n_cmp++;
    if (m_rdata !== '0) begin
      n_err++;
      $display("FAIL rst_m_rdata: got %h exp 0", m_rdata);
    end
    tick();
    settle();
    n_cmp++;
    if ({s_awvalid, s_arvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_held_valid: got %b exp 00", {s_awvalid, s_arvalid});
    end
  endtask

  task automatic test_write_arb();
    nreset = 1'b0;
    clear_inputs();
    m_awaddr = {32'h2000_0010, 32'h1000_0000};
    m_wdata  = {32'hBBBB_0001, 32'hAAAA_0000};
    m_wstrb  = '1; m_wlast = 2'b11; m_wvalid = 2'b11; m_awvalid = 2'b11; m_bready = 2'b11;
    tick();
    nreset = 1'b1;
    settle();
    n_cmp++;
    if (s_awvalid !== 1'b0) begin
      n_err++; $display("FAIL arb_latency_idle: got %b exp 0", s_awvalid);
    end
    tick();
    settle();
    n_cmp++;
    if ({s_awvalid, s_awaddr, s_wdata} !== {1'b1, 32'h1000_0000, 32'hAAAA_0000}) begin
      n_err++; $display("FAIL arb_first_m0: got %b %h %h exp 1 10000000 aaaa0000", s_awvalid, s_awaddr, s_wdata);
    end
    tick();
    s_awready = 1'b1; s_wready = 1'b1;
    settle();
    n_cmp++;
    if ({m_awready, m_wready} !== 4'b0101) begin
      n_err++; $display("FAIL arb_m0_ready: got %b exp 0101", {m_awready, m_wready});
    end
    tick();
    s_awready = 1'b0; s_wready = 1'b0;
    m_awvalid = 2'b10; m_wvalid = 2'b10;
    settle();
    n_cmp++;
    if ({s_awvalid, m_bvalid} !== 3'b000) begin
      n_err++; $display("FAIL arb_m1_wait_resp: got %b exp 000", {s_awvalid, m_bvalid});
    end
    tick();
    s_bvalid = 1'b1;
    settle();
    n_cmp++;
    if ({m_bvalid, s_bready} !== 3'b011) begin
      n_err++; $display("FAIL arb_m0_bresp: got %b exp 011", {m_bvalid, s_bready});
    end
    tick();
    s_bvalid = 1'b0;
    settle();
    n_cmp++;
    if (s_awvalid !== 1'b0) begin
      n_err++; $display("FAIL arb_gap_cycle: got %b exp 0", s_awvalid);
    end
    tick();
    settle();
    n_cmp++;
    if ({s_awvalid, s_awaddr} !== {1'b1, 32'h2000_0010}) begin
      n_err++; $display("FAIL arb_then_m1: got %b %h exp 1 20000010", s_awvalid, s_awaddr);
    end
    tick();
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    s_awready = 1'b0; s_wready = 1'b0; m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b1;
    settle();
    n_cmp++;
    if (m_bvalid !== 2'b10) begin
      n_err++; $display("FAIL arb_m1_bresp: got %b exp 10", m_bvalid);
    end
    tick();
    s_bvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addr_tbl [N];
    int            exp;
    addr_tbl[0] = 32'h0000_1000;
    addr_tbl[1] = 32'h0000_2000;
    apply_reset();
    m_awaddr = {addr_tbl[1], addr_tbl[0]};
    m_awvalid = 2'b11; m_wvalid = 2'b11; m_wlast = 2'b11; m_bready = 2'b11; m_wstrb = '1;
    for (int k = 0; k < 8; k++) begin
      exp = k % 2;
      tick();
      s_awready = 1'b1; s_wready = 1'b1;
      settle();
      n_cmp++;
      if ({s_awaddr, m_awready} !== {addr_tbl[exp], 2'(1 << exp)}) begin
        n_err++; $display("FAIL b2b_grant_%0d: got %h %b exp %h %b", k, s_awaddr, m_awready, addr_tbl[exp], 2'(1 << exp));
      end
      tick();
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1;
      settle();
      n_cmp++;
      if (m_bvalid !== 2'(1 << exp)) begin
        n_err++; $display("FAIL b2b_bvalid_%0d: got %b exp %b", k, m_bvalid, 2'(1 << exp));
      end
      tick();
      s_bvalid = 1'b0;
    end
  endtask

  task automatic test_read_burst();
    int pulses;
    pulses = 0;
    apply_reset();
    m_araddr = {32'h0000_3000, 32'h0000_0000}; m_arlen = {8'd3, 8'd0};
    m_arvalid = 2'b10; m_rready = 2'b11;
    tick();
    s_arready = 1'b1;
    settle();
    n_cmp++;
    if ({s_arvalid, s_araddr, s_arlen, m_arready} !== {1'b1, 32'h0000_3000, 8'd3, 2'b10}) begin
      n_err++; $display("FAIL rd_addr_m1: got %b %h %0d %b exp 1 00003000 3 10", s_arvalid, s_araddr, s_arlen, m_arready);
    end
    tick();
    s_arready = 1'b0; m_arvalid = '0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rdata = 32'hA0 + 32'(b);
      settle();
      if (m_rvalid[1]) pulses++;
      n_cmp++;
      if ({m_rvalid, m_rdata} !== {2'b10, 32'hA0 + 32'(b), 32'h0}) begin
        n_err++; $display("FAIL rd_beat_%0d: got %b %h exp 10 %h00000000", b, m_rvalid, m_rdata, 32'hA0 + 32'(b));
      end
      tick();
      s_rvalid = 1'b0;
      settle();
      if (m_rvalid[1]) pulses++;
      n_cmp++;
      if (m_rvalid !== 2'b00) begin
        n_err++; $display("FAIL rd_gap_%0d: got %b exp 00", b, m_rvalid);
      end
      tick();
    end
    s_rvalid = 1'b1; s_rdata = 32'hEE;
    settle();
    if (m_rvalid[1]) pulses++;
    n_cmp++;
    if ({m_rvalid, s_rready, m_rdata} !== {3'b000, 64'h0}) begin
      n_err++; $display("FAIL rd_released: got %b %b %h exp 00 0 0", m_rvalid, s_rready, m_rdata);
    end
    n_cmp++;
    if (pulses !== 4) begin
      n_err++; $display("FAIL rd_pulse_count: got %0d exp 4", pulses);
    end
    tick();
    s_rvalid = 1'b0;
  endtask

  task automatic test_concurrent();
    apply_reset();
    m_awaddr = {32'h0, 32'h0000_7000}; m_wdata = {32'h0, 32'h1234_5678};
    m_wstrb = '1; m_wlast = 2'b01; m_wvalid = 2'b01; m_awvalid = 2'b01; m_bready = 2'b11;
    m_araddr = {32'h0000_8000, 32'h0}; m_arvalid = 2'b10; m_rready = 2'b11;
    tick();
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    settle();
    n_cmp++;
    if ({s_awvalid, s_arvalid, s_awaddr, s_araddr, s_wdata} !== {2'b11, 32'h0000_7000, 32'h0000_8000, 32'h1234_5678}) begin
      n_err++; $display("FAIL cc_addr: got %b%b %h %h %h", s_awvalid, s_arvalid, s_awaddr, s_araddr, s_wdata);
    end
    n_cmp++;
    if ({m_awready, m_wready, m_arready} !== 6'b01_01_10) begin
      n_err++; $display("FAIL cc_ready: got %b exp 010110", {m_awready, m_wready, m_arready});
    end
    tick();
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    s_bvalid = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
    settle();
    n_cmp++;
    if ({m_bvalid, m_rvalid, m_rdata} !== {2'b01, 2'b10, 32'h5555_AAAA, 32'h0}) begin
      n_err++; $display("FAIL cc_resp: got %b %b %h", m_bvalid, m_rvalid, m_rdata);
    end
    tick();
    s_bvalid = 1'b0; s_rvalid = 1'b0;
  endtask

  task automatic test_w_before_aw();
    apply_reset();
    m_awaddr = {32'h0, 32'h0000_9000}; m_wlast = 2'b01; m_wvalid = 2'b01;
    m_wstrb = '1; m_bready = 2'b01; s_wready = 1'b1;
    settle();
    n_cmp++;
    if ({m_wready, s_wvalid} !== 3'b000) begin
      n_err++; $display("FAIL wfirst_stall: got %b exp 000", {m_wready, s_wvalid});
    end
    tick();
    m_awvalid = 2'b01; s_wready = 1'b0;
    tick();
    s_wready = 1'b1;
    settle();
    n_cmp++;
    if ({m_wready, m_awready} !== 4'b0100) begin
      n_err++; $display("FAIL wfirst_w_hs: got %b exp 0100", {m_wready, m_awready});
    end
    tick();
    s_wready = 1'b0; m_wvalid = '0;
    settle();
    n_cmp++;
    if ({s_awvalid, s_wvalid} !== 2'b10) begin
      n_err++; $display("FAIL wfirst_hold_aw: got %b exp 10", {s_awvalid, s_wvalid});
    end
    tick();
    s_awready = 1'b1;
    settle();
    n_cmp++;
    if (m_awready !== 2'b01) begin
      n_err++; $display("FAIL wfirst_aw_hs: got %b exp 01", m_awready);
    end
    tick();
    s_awready = 1'b0; m_awvalid = '0; s_bvalid = 1'b1;
    settle();
    n_cmp++;
    if ({m_bvalid, s_bready} !== 3'b011) begin
      n_err++; $display("FAIL wfirst_resp: got %b exp 011", {m_bvalid, s_bready});
    end
    tick();
    s_bvalid = 1'b0;
  endtask

  task automatic test_long_burst();
    int seen;
    seen = 0;
    apply_reset();
    m_araddr = {32'h0, 32'h0000_A000}; m_arlen = {8'd0, 8'd255};
    m_arvalid = 2'b01; m_rready = 2'b01;
    tick();
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid = '0;
    for (int b = 0; b < 256; b++) begin
      s_rvalid = 1'b1; s_rdata = DW'(b);
      settle();
      if (m_rvalid === 2'b01) seen++;
      if (b == 255) begin
        n_cmp++;
        if (m_rdata[DW-1:0] !== 32'd255) begin
          n_err++; $display("FAIL long_last_data: got %h exp 000000ff", m_rdata[DW-1:0]);
        end
      end
      tick();
    end
    settle();
    n_cmp++;
    if (seen !== 256) begin
      n_err++; $display("FAIL long_beat_count: got %0d exp 256", seen);
    end
    n_cmp++;
    if ({s_rready, m_rvalid} !== 3'b000) begin
      n_err++; $display("FAIL long_released: got %b exp 000", {s_rready, m_rvalid});
    end
    tick();
    s_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    m_araddr = {32'h0000_5000, 32'h0000_4000}; m_arlen = {8'd0, 8'd5};
    m_arvalid = 2'b01; m_rready = 2'b01;
    tick();
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001;
    tick();
    tick();
    tick();
    settle();
    n_cmp++;
    if ({m_rvalid, s_rready} !== 3'b011) begin
      n_err++; $display("FAIL midrst_active: got %b exp 011", {m_rvalid, s_rready});
    end
    nreset = 1'b0;
    #1;
    n_cmp++;
    if ({m_rvalid, s_rready, s_arvalid, m_rdata} !== {4'b0000, 64'h0}) begin
      n_err++; $display("FAIL midrst_outputs: got %b %b %b %h exp 0", m_rvalid, s_rready, s_arvalid, m_rdata);
    end
    tick();
    nreset = 1'b1; s_rvalid = 1'b0; m_arvalid = 2'b11; m_arlen = '0;
    tick();
    settle();
    n_cmp++;
    if ({s_arvalid, s_araddr} !== {1'b1, 32'h0000_4000}) begin
      n_err++; $display("FAIL midrst_regrant_m0: got %b %h exp 1 00004000", s_arvalid, s_araddr);
    end
    tick();
    m_arvalid = '0;
  endtask

  initial begin
    nreset = 1'b0;
    clear_inputs();
    test_reset();
    test_write_arb();
    test_back_to_back();
    test_read_burst();
    test_concurrent();
    test_w_before_aw();
    test_long_burst();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
